// File: rtl/seq_pkg.sv
// seq_pkg: shared state type and marker constants for the 10011 serial link
package seq_pkg;
  localparam int SEQ_PAT_LEN = 5;
  localparam logic [SEQ_PAT_LEN-1:0] SEQ_PATTERN = 5'b10011;
  localparam int SEQ_MIN_GAP = 3;
  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_GAP} seq_state_e;
  function automatic int seq_max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/seq_tx_shifter.sv
// seq_tx_shifter: loadable MSB-first frame shifter plus per-phase down-counter
module seq_tx_shifter #(
  parameter int W  = 13,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [W-1:0]  i_load_val,
  input  logic          i_shift,
  input  logic          i_cnt_load,
  input  logic [CW-1:0] i_cnt_val,
  output logic          o_msb,
  output logic          o_tc
);
  logic [W-1:0]  r_sr;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      r_sr  <= i_load ? i_load_val : i_shift ? {r_sr[W-2:0], 1'b0} : r_sr;
      r_cnt <= i_cnt_load ? i_cnt_val : (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
    end
  end
  assign o_msb = r_sr[W-1];
  assign o_tc  = (r_cnt == '0);
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: sends marker, MSB-first payload, then GAP zeros per start request
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int                   DATA_W  = 8,
  parameter int                   PAT_LEN = SEQ_PAT_LEN,
  parameter logic [PAT_LEN-1:0]   PATTERN = SEQ_PATTERN,
  parameter int                   GAP     = SEQ_MIN_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              outp,
  output logic              busy,
  output logic              bit_valid,
  output logic              done
);
  localparam int CW = $clog2(seq_max3(PAT_LEN, DATA_W, GAP));
  localparam logic [CW-1:0] C_PRE = CW'(PAT_LEN - 1);
  localparam logic [CW-1:0] C_PAY = CW'(DATA_W - 1);
  localparam logic [CW-1:0] C_GAP = CW'(GAP - 1);
  seq_state_e    r_state;
  seq_state_e    w_next;
  logic          w_accept;
  logic          w_tc;
  logic          w_msb;
  logic          w_cnt_load;
  logic [CW-1:0] w_cnt_val;
  assign w_accept = (r_state == S_IDLE) && start;
  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    case (r_state)
      S_IDLE:     if (start) begin w_next = S_PREAMBLE; w_cnt_load = 1'b1; w_cnt_val = C_PRE; end
      S_PREAMBLE: if (w_tc)  begin w_next = S_PAYLOAD;  w_cnt_load = 1'b1; w_cnt_val = C_PAY; end
      S_PAYLOAD:  if (w_tc)  begin w_next = S_GAP;      w_cnt_load = 1'b1; w_cnt_val = C_GAP; end
      default:    if (w_tc)  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end
  // Zeros shift in behind the payload, so the gap phase needs no separate mux.
  seq_tx_shifter #(.W(PAT_LEN + DATA_W), .CW(CW)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_load_val({PATTERN, data_in}),
    .i_shift   (r_state != S_IDLE),
    .i_cnt_load(w_cnt_load),
    .i_cnt_val (w_cnt_val),
    .o_msb     (w_msb),
    .o_tc      (w_tc)
  );
  assign outp      = w_msb;
  assign busy      = (r_state != S_IDLE);
  assign bit_valid = (r_state == S_PREAMBLE) || (r_state == S_PAYLOAD);
  assign done      = (r_state == S_GAP) && w_tc;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: random and directed frames checked against a frame-index model
module tb_seq_pattern_tx;
  import seq_pkg::*;
  localparam int DW = 8;
  localparam int PL = SEQ_PAT_LEN;
  localparam int G  = SEQ_MIN_GAP;
  localparam int F  = PL + DW + G;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic outp, busy, bit_valid, done;
  logic start1 = 1'b0;
  logic [0:0] data1 = 1'b0;
  logic outp1, busy1, bit_valid1, done1;
  int errors = 0, checks = 0, cyc = 0;
  logic chk_en = 1'b0;
  seq_pattern_tx #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .outp(outp), .busy(busy), .bit_valid(bit_valid), .done(done)
  );
  seq_pattern_tx #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data1),
    .outp(outp1), .busy(busy1), .bit_valid(bit_valid1), .done(done1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Model: frame index m_idx (-1 when idle) into the bit string {marker, payload, zeros}.
  int m_idx = -1;
  logic [F-1:0] m_frame = '0;
  always @(posedge clk) begin
    cyc++;
    if (!rst) m_idx = -1;
    else if (m_idx < 0) begin
      if (start) begin
        m_idx = 0;
        m_frame = {SEQ_PATTERN, data_in, {G{1'b0}}};
      end
    end else begin
      m_idx++;
      if (m_idx == F) m_idx = -1;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("outp", 32'(outp), (m_idx >= 0) ? 32'(m_frame[F-1-m_idx]) : 32'd0);
      chk("busy", 32'(busy), 32'(m_idx >= 0));
      chk("bit_valid", 32'(bit_valid), 32'(m_idx >= 0 && m_idx < PL + DW));
      chk("done", 32'(done), 32'(m_idx == F - 1));
    end
  end
  task automatic cap(output logic [F-1:0] v, output int done_cyc, output int done_n);
    done_cyc = -1;
    done_n = 0;
    for (int i = 0; i < F; i++) begin
      v[F-1-i] = outp;
      if (done) begin done_cyc = cyc; done_n++; end
      @(negedge clk);
    end
  endtask
  task automatic send(input logic [DW-1:0] d);
    data_in = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  logic [F-1:0] v;
  int d1, d2, n;
  logic [8:0] v1;
  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_outp", 32'(outp), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    send(8'hA5);
    cap(v, d1, n);
    chk("t1_frame", 32'(v), 32'b1001110100101000);
    chk("t1_done_n", 32'(n), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);
    send(8'h00);
    cap(v, d1, n);
    chk("t2_frame0", 32'(v), 32'b1001100000000000);
    chk("t2_idle_outp", 32'(outp), 32'd0);
    send(8'hFF);
    cap(v, d2, n);
    chk("t2_frame1", 32'(v), 32'b1001111111111000);
    chk("t2_done_gap", 32'(d2 - d1), 32'(F + 1));
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      data_in = DW'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (F + 2) @(negedge clk);
    send(8'hA5);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_outp", 32'(outp), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(bit_valid), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    send(8'h3C);
    data_in = 8'hFF;
    cap(v, d1, n);
    chk("t4_frame", 32'(v), 32'b1001100111100000);
    chk("t4_done_n", 32'(n), 32'd1);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 39) != 0);
      start = ($urandom_range(0, 3) == 0);
      data_in = DW'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    start = 1'b0;
    repeat (F + 2) @(negedge clk);
    data1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    d1 = -1;
    for (int i = 0; i < 9; i++) begin
      v1[8-i] = outp1;
      if (done1) begin n++; d1 = i + 1; end
      @(negedge clk);
    end
    chk("t6_frame", 32'(v1), 32'b100111000);
    chk("t6_done_at", 32'(d1), 32'd9);
    chk("t6_done_n", 32'(n), 32'd1);
    chk("t6_busy_after", 32'(busy1), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
